conv_result_streamer: RTL

//  Transmit side of the kernel-application datapath. Takes the raster-ordered

---
 rtl/conv_result_streamer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/conv_result_streamer.sv
// conv_result_streamer
//   Converts raster-ordered signed convolution results into an 8-bit pixel
//   stream with start-of-frame / end-of-line / end-of-frame markers. The
//   kernel border ring is forced to zero and every other result is saturated
//   according to the conversion mode latched at the start of the frame.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   mode         00/11 signed sat, 01 |x| sat, 10 x+128 sat
//   s_valid/s_ready/s_data   input result stream (signed IN_W)
//   m_valid/m_ready/m_data   output pixel stream (OUT_W)
//   m_sof/m_eol/m_eof        position markers of the presented beat
//   busy         frame in progress
//   frame_done   one-cycle pulse after the EOF beat is taken downstream
module conv_result_streamer #(
  parameter int ROWS   = 242,
  parameter int COLS   = 247,
  parameter int K_ROWS = 3,
  parameter int K_COLS = 3,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_W-1:0]       m_data,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic                   m_eof,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam int BR = K_ROWS >> 1;
  localparam int BC = K_COLS >> 1;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LO   = RW'(BR);
  localparam logic [RW-1:0] ROW_HI   = RW'(ROWS - BR);
  localparam logic [CW-1:0] COL_LO   = CW'(BC);
  localparam logic [CW-1:0] COL_HI   = CW'(COLS - BC);

  localparam int S_MAX = (2 ** (OUT_W - 1)) - 1;
  localparam int S_MIN = -(2 ** (OUT_W - 1));
  localparam int U_MAX = (2 ** OUT_W) - 1;
  localparam int OFFS  = 2 ** (OUT_W - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [1:0]      r_mode_q, w_mode_nxt;
  logic            w_fd_nxt;
  logic            w_in_beat, w_out_beat;
  logic            w_last_row, w_last_col, w_border;
  logic [1:0]      w_mode_eff;

  // The whole computation is done one bit wider than the input so that
  // |min| and x+OFFS cannot wrap before the clamp.
  function automatic logic [OUT_W-1:0] sat_pix(input logic signed [IN_W-1:0] x,
                                               input logic [1:0] md);
    logic signed [IN_W:0] w;
    logic signed [IN_W:0] lo;
    logic signed [IN_W:0] hi;
    w = {x[IN_W-1], x};
    case (md)
      2'b01: begin
        if (w[IN_W]) w = -w;
        lo = '0;
        hi = (IN_W+1)'(U_MAX);
      end
      2'b10: begin
        w  = w + (IN_W+1)'(OFFS);
        lo = '0;
        hi = (IN_W+1)'(U_MAX);
      end
      default: begin
        lo = (IN_W+1)'(S_MIN);
        hi = (IN_W+1)'(S_MAX);
      end
    endcase
    if (w > hi)      w = hi;
    else if (w < lo) w = lo;
    return w[OUT_W-1:0];
  endfunction

  assign s_ready    = (r_state != DRAIN) && (!m_valid || m_ready);
  assign w_in_beat  = s_valid && s_ready;
  assign w_out_beat = m_valid && m_ready;
  assign busy       = (r_state != IDLE);

  assign w_last_row = (r_row == LAST_ROW);
  assign w_last_col = (r_col == LAST_COL);
  assign w_border   = (r_row < ROW_LO) || (r_row >= ROW_HI) ||
                      (r_col < COL_LO) || (r_col >= COL_HI);

  // The first beat of a frame is converted with the live mode input, since
  // the latched copy only becomes valid on the following cycle.
  assign w_mode_eff = (r_state == IDLE) ? mode : r_mode_q;

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_mode_nxt  = r_mode_q;
    w_fd_nxt    = 1'b0;
    case (r_state)
      IDLE, ACTIVE: begin
        if (w_in_beat) begin
          if (r_state == IDLE) w_mode_nxt = mode;
          if (w_last_col) begin
            w_col_nxt = '0;
            if (w_last_row) begin
              // Counters are already back at (0,0) for the next frame.
              w_row_nxt   = '0;
              w_state_nxt = DRAIN;
            end else begin
              w_row_nxt   = r_row + RW'(1);
              w_state_nxt = ACTIVE;
            end
          end else begin
            w_col_nxt   = r_col + CW'(1);
            w_state_nxt = ACTIVE;
          end
        end
      end
      DRAIN: begin
        if (w_out_beat) begin
          w_fd_nxt    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // input acceptance -> output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_mode_q   <= 2'b00;
      frame_done <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      m_eof      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_mode_q   <= w_mode_nxt;
      frame_done <= w_fd_nxt;
      if (w_in_beat) begin
        m_valid <= 1'b1;
        m_data  <= w_border ? '0 : sat_pix(s_data, w_mode_eff);
        m_sof   <= (r_row == '0) && (r_col == '0);
        m_eol   <= w_last_col;
        m_eof   <= w_last_col && w_last_row;
      end else if (w_out_beat) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
